rv32i_pipe_ctrl: RTL and testbench

Pipeline sequencer for the rv32i_pipe core. Generates the per-stage advance enables (fetch, decode, execute, writeback) and the decode `clear_i` flush. It tracks a valid bit per stage and resolves three events each cycle:

- execute-stage memory wait
- load-use hazards
- taken-branch flushes

A small FSM adds a debugger-style halt/drain/resume sequence. The block sits beside the stage registers and drives `rv32i_decode.data_ready_i` and `clear_i`.

---
 rtl/rv32i_pipe_ctrl.sv | 111 +++++++++++
 tb/tb_rv32i_pipe_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_pipe_ctrl.sv
// rv32i_pipe_ctrl: per-stage advance enables, decode flush and halt/drain/resume FSM for rv32i_pipe.
// Outputs are combinational (0 cycles). Execute memory wait holds the pipe. Optional counters: RV32I_PIPE_CTRL_PERF_EN.
module rv32i_pipe_ctrl #(
  parameter int REG_BITS = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fetch_valid_i,
  input  logic [REG_BITS-1:0] dec_rs1_addr_i,
  input  logic [REG_BITS-1:0] dec_rs2_addr_i,
  input  logic                dec_uses_rs1_i,
  input  logic                dec_uses_rs2_i,
  input  logic [REG_BITS-1:0] ex_rd_addr_i,
  input  logic                ex_is_load_i,
  input  logic                mem_busy_i,
  input  logic                branch_taken_i,
  input  logic                halt_req_i,
  input  logic                resume_i,
  output logic                fetch_ce_o,
  output logic                pc_load_o,
  output logic                decode_ce_o,
  output logic                clear_o,
  output logic                execute_ce_o,
  output logic                writeback_ce_o,
  output logic                halted_o,
  output logic [31:0]         stall_cycles_o,
  output logic [31:0]         flush_count_o
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e state_q, state_d;
  logic   v_d_q, v_e_q, v_w_q;
  logic   v_d_d, v_e_d, v_w_d;
  logic   hold_e, load_use, flush, ex_ce, d_adv, dec_ce;
  logic   rs1_hit, rs2_hit;

  assign hold_e   = v_e_q & mem_busy_i;
  assign rs1_hit  = dec_uses_rs1_i & (dec_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit  = dec_uses_rs2_i & (dec_rs2_addr_i == ex_rd_addr_i);
  assign load_use = v_d_q & v_e_q & ex_is_load_i & (ex_rd_addr_i != '0) & (rs1_hit | rs2_hit);
  assign flush    = v_e_q & branch_taken_i & ~hold_e;
  assign ex_ce    = v_d_q & ~hold_e & ~load_use & ~flush;
  assign d_adv    = ~v_d_q | ex_ce;
  // Valid bits are already cleared in reset, but the fetch path depends only on inputs.
  assign dec_ce   = rst_ni & fetch_valid_i & d_adv & ~flush & (state_q == RUN);

  assign writeback_ce_o = v_e_q & ~hold_e;
  assign execute_ce_o   = ex_ce;
  assign decode_ce_o    = dec_ce;
  assign fetch_ce_o     = dec_ce;
  assign clear_o        = flush;
  assign pc_load_o      = flush;
  assign halted_o       = (state_q == HALTED);

  assign v_w_d = writeback_ce_o;
  assign v_e_d = hold_e ? 1'b1 : ex_ce;
  assign v_d_d = flush ? 1'b0 : (d_adv ? dec_ce : v_d_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!(v_d_q | v_e_q | v_w_q)) state_d = HALTED;
        else if (!halt_req_i)         state_d = RUN;
      end
      HALTED:  if (resume_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      v_d_q   <= 1'b0;
      v_e_q   <= 1'b0;
      v_w_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v_d_q   <= v_d_d;
      v_e_q   <= v_e_d;
      v_w_q   <= v_w_d;
    end
  end

`ifdef RV32I_PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  assign stall_cnt_d = ((hold_e | load_use) && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign flush_cnt_d = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + 32'd1 : flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl: per-cycle expected enable vectors queued at drive time, popped at the sample point.
// Output vector order: {fetch_ce, pc_load, decode_ce, clear, execute_ce, writeback_ce, halted}.
module tb_rv32i_pipe_ctrl;
  localparam int RB = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          fetch_valid_i;
  logic [RB-1:0] dec_rs1_addr_i, dec_rs2_addr_i, ex_rd_addr_i;
  logic          dec_uses_rs1_i, dec_uses_rs2_i;
  logic          ex_is_load_i, mem_busy_i, branch_taken_i, halt_req_i, resume_i;
  logic          fetch_ce_o, pc_load_o, decode_ce_o, clear_o, execute_ce_o, writeback_ce_o, halted_o;
  logic [31:0]   stall_cycles_o, flush_count_o;

  typedef logic [6:0] ovec_t;
  ovec_t exp_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  always #5 clk_i = ~clk_i;

  rv32i_pipe_ctrl #(.REG_BITS(RB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch_valid_i(fetch_valid_i),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
    .dec_uses_rs1_i(dec_uses_rs1_i), .dec_uses_rs2_i(dec_uses_rs2_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_is_load_i(ex_is_load_i), .mem_busy_i(mem_busy_i),
    .branch_taken_i(branch_taken_i), .halt_req_i(halt_req_i), .resume_i(resume_i),
    .fetch_ce_o(fetch_ce_o), .pc_load_o(pc_load_o), .decode_ce_o(decode_ce_o), .clear_o(clear_o),
    .execute_ce_o(execute_ce_o), .writeback_ce_o(writeback_ce_o), .halted_o(halted_o),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  function automatic ovec_t outs();
    return {fetch_ce_o, pc_load_o, decode_ce_o, clear_o, execute_ce_o, writeback_ce_o, halted_o};
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef RV32I_PIPE_CTRL_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already driven, expectation queued, sampled on the falling edge.
  task automatic cyc(input string tag, input ovec_t e);
    exp_q.push_back(e);
    @(negedge clk_i);
    check_eq(tag, 32'(outs()), 32'(exp_q.pop_front()));
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    fetch_valid_i = 1'b1;
    dec_rs1_addr_i = '0; dec_rs2_addr_i = '0; ex_rd_addr_i = '0;
    dec_uses_rs1_i = 1'b0; dec_uses_rs2_i = 1'b0;
    ex_is_load_i = 1'b0; mem_busy_i = 1'b0; branch_taken_i = 1'b0;
    halt_req_i = 1'b0; resume_i = 1'b0;
  endtask

  task automatic load_in(input logic [RB-1:0] rd, input logic u1, input logic [RB-1:0] rs1,
                         input logic u2, input logic [RB-1:0] rs2);
    ex_is_load_i = 1'b1; ex_rd_addr_i = rd;
    dec_uses_rs1_i = u1; dec_rs1_addr_i = rs1;
    dec_uses_rs2_i = u2; dec_rs2_addr_i = rs2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    idle_in();
    @(posedge clk_i); #1;
    cyc("reset_outs", 7'b0000000);
    check_eq("reset_stall_cnt", stall_cycles_o, 32'd0);
    check_eq("reset_flush_cnt", flush_count_o, 32'd0);
    rst_ni = 1'b1;

    // Fill: decode, then execute, then writeback come alive
    cyc("fill_c0", 7'b1010000);
    cyc("fill_c1", 7'b1010100);
    cyc("fill_c2", 7'b1010110);
    cyc("fill_c3", 7'b1010110);

    // Load-use on rs1 = x5: one bubble
    load_in(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    cyc("lu_rs1_stall", 7'b0000010);
    idle_in();
    cyc("lu_rs1_resume", 7'b1010100);
    load_in(5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    cyc("lu_rd0_nostall", 7'b1010110);
    load_in(5'd7, 1'b1, 5'd3, 1'b1, 5'd7);
    cyc("lu_rs2_stall", 7'b0000010);
    idle_in();
    cyc("lu_rs2_resume", 7'b1010100);
    load_in(5'd5, 1'b0, 5'd5, 1'b0, 5'd0);
    cyc("lu_unused_rs1", 7'b1010110);
    idle_in();
    check_eq("lu_stall_cnt", stall_cycles_o, perf(32'd2));

    // Taken branch: flush same cycle, refetch from target
    branch_taken_i = 1'b1;
    cyc("br_flush", 7'b0101010);
    branch_taken_i = 1'b0;
    check_eq("br_flush_cnt", flush_count_o, perf(32'd1));
    cyc("br_target_dec", 7'b1010000);
    cyc("br_target_ex", 7'b1010100);
    cyc("br_refilled", 7'b1010110);

    // Memory wait with a pending taken branch: flush waits for the hold to clear
    mem_busy_i = 1'b1; branch_taken_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("hold_%0d", i), 7'b0000000);
    mem_busy_i = 1'b0;
    cyc("hold_late_flush", 7'b0101010);
    branch_taken_i = 1'b0;
    check_eq("hold_stall_cnt", stall_cycles_o, perf(32'd5));
    check_eq("hold_flush_cnt", flush_count_o, perf(32'd2));

    // Refill, then halt with three in flight
    cyc("refill_0", 7'b1010000);
    cyc("refill_1", 7'b1010100);
    cyc("refill_2", 7'b1010110);
    halt_req_i = 1'b1;
    cyc("halt_req_run", 7'b1010110);
    cyc("drain_0", 7'b0000110);
    cyc("drain_1", 7'b0000010);
    resume_i = 1'b1;
    cyc("drain_resume_ignored", 7'b0000000);
    resume_i = 1'b0;
    cyc("drain_empty", 7'b0000000);
    cyc("halted", 7'b0000001);
    halt_req_i = 1'b0; resume_i = 1'b1;
    cyc("halted_resume", 7'b0000001);
    resume_i = 1'b0;
    cyc("post_resume_dec", 7'b1010000);

    // Halt request withdrawn before the pipeline empties
    halt_req_i = 1'b1;
    cyc("abort_req", 7'b1010100);
    halt_req_i = 1'b0;
    cyc("abort_drain", 7'b0000110);
    cyc("abort_back_run", 7'b1010010);

    // Build a stall, then pull reset mid-operation
    cyc("pre_rst_0", 7'b1010100);
    mem_busy_i = 1'b1;
    cyc("pre_rst_hold", 7'b0000000);
    mem_busy_i = 1'b0;
    load_in(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    cyc("pre_rst_lu", 7'b0000010);
    check_eq("pre_rst_stall_cnt", stall_cycles_o, perf(32'd7));
    idle_in();
    #1;
    check_eq("pre_rst_live", 32'(outs()), 32'(7'b1010100));
    rst_ni = 1'b0;
    #1;
    check_eq("async_rst_outs", 32'(outs()), 32'd0);
    check_eq("async_rst_stall_cnt", stall_cycles_o, 32'd0);
    check_eq("async_rst_flush_cnt", flush_count_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc("post_rst_first", 7'b1010000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
